i2c_xfer_sequencer: RTL and testbench

Transaction-level front end for `i2c_master`: accepts one request (7-bit address, direction, byte count) and drives the master's command stream and write-data stream. It forwards read data back with `tlast` on the final byte and reports completion and missed-ACK status. It sits directly upstream of `i2c_master` and replaces hand-driven `s_axis_cmd_*` and `s_axis_data_*` stimulus.

---
 rtl/i2c_xfer_if.sv | 83 ++++++++
 rtl/i2c_xfer_sequencer.sv | 143 ++++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_xfer_if.sv
// Bundle of request, user-stream and i2c_master-facing signals for the transfer sequencer.
// Every valid/ready pair: a beat moves on a rising clk edge where both are 1; valid never waits on ready.
interface i2c_xfer_if #(
    parameter int LEN_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_addr;
    logic             req_read;
    logic [LEN_W-1:0] req_len;

    logic [7:0]       s_axis_wr_tdata;
    logic             s_axis_wr_tvalid;
    logic             s_axis_wr_tready;

    logic [7:0]       m_axis_rd_tdata;
    logic             m_axis_rd_tvalid;
    logic             m_axis_rd_tready;
    logic             m_axis_rd_tlast;

    logic [6:0]       m_axis_cmd_address;
    logic             m_axis_cmd_start;
    logic             m_axis_cmd_read;
    logic             m_axis_cmd_write;
    logic             m_axis_cmd_write_multiple;
    logic             m_axis_cmd_stop;
    logic             m_axis_cmd_valid;
    logic             m_axis_cmd_ready;

    logic [7:0]       m_axis_data_tdata;
    logic             m_axis_data_tvalid;
    logic             m_axis_data_tready;
    logic             m_axis_data_tlast;

    logic [7:0]       s_axis_data_tdata;
    logic             s_axis_data_tvalid;
    logic             s_axis_data_tready;
    logic             s_axis_data_tlast;

    logic             master_busy;
    logic             missed_ack;

    logic             done;
    logic             err_nack;
    logic             err_len;
    logic             busy;

    modport master (
        input  req_valid, req_addr, req_read, req_len,
        output req_ready,
        input  s_axis_wr_tdata, s_axis_wr_tvalid,
        output s_axis_wr_tready,
        output m_axis_rd_tdata, m_axis_rd_tvalid, m_axis_rd_tlast,
        input  m_axis_rd_tready,
        output m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
        output m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
        input  m_axis_cmd_ready,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  m_axis_data_tready,
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        output s_axis_data_tready,
        input  master_busy, missed_ack,
        output done, err_nack, err_len, busy
    );

    modport slave (
        output req_valid, req_addr, req_read, req_len,
        input  req_ready,
        output s_axis_wr_tdata, s_axis_wr_tvalid,
        input  s_axis_wr_tready,
        input  m_axis_rd_tdata, m_axis_rd_tvalid, m_axis_rd_tlast,
        output m_axis_rd_tready,
        input  m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
        input  m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
        output m_axis_cmd_ready,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output m_axis_data_tready,
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        input  s_axis_data_tready,
        output master_busy, missed_ack,
        input  done, err_nack, err_len, busy
    );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Turns one {addr, read, len} request into i2c_master command/data streams and reports completion.
// Command channel is registered; write and read byte paths are zero-latency pass-throughs.
module i2c_xfer_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    i2c_xfer_if.master  bus,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD_WR    = 3'd1,
        DATA_WR   = 3'd2,
        CMD_RD    = 3'd3,
        WAIT_RD   = 3'd4,
        WAIT_IDLE = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] cmd_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic             master_busy_q;
    logic             wr_active;
    logic             rd_active;
    logic             req_fire;
    logic             cmd_fire;
    logic             wr_beat;
    logic             rd_beat;
    logic             unused_tlast;

    assign dbg_state    = state;
    assign unused_tlast = bus.s_axis_data_tlast;
    assign last_idx     = len_q - LEN_W'(1);

    // req_ready is gated by rst so it reads 0 for the whole reset window.
    assign bus.req_ready = rst && (state == IDLE);
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign cmd_fire      = bus.m_axis_cmd_valid && bus.m_axis_cmd_ready;

    assign wr_active = (state == DATA_WR);
    assign rd_active = (state == CMD_RD) || (state == WAIT_RD);
    assign wr_beat   = wr_active && bus.s_axis_wr_tvalid && bus.m_axis_data_tready;
    assign rd_beat   = rd_active && bus.s_axis_data_tvalid && bus.m_axis_rd_tready;

    assign bus.m_axis_data_tdata  = wr_active ? bus.s_axis_wr_tdata : 8'h00;
    assign bus.m_axis_data_tvalid = wr_active && bus.s_axis_wr_tvalid;
    assign bus.m_axis_data_tlast  = wr_active && (wr_cnt == last_idx);
    assign bus.s_axis_wr_tready   = wr_active && bus.m_axis_data_tready;

    assign bus.m_axis_rd_tdata    = rd_active ? bus.s_axis_data_tdata : 8'h00;
    assign bus.m_axis_rd_tvalid   = rd_active && bus.s_axis_data_tvalid;
    assign bus.m_axis_rd_tlast    = rd_active && (rd_cnt == last_idx);
    assign bus.s_axis_data_tready = rd_active && bus.m_axis_rd_tready;

    assign bus.m_axis_cmd_start = 1'b0;
    assign bus.m_axis_cmd_write = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (bus.req_len == '0) state_nxt = DONE;
                    else if (bus.req_read)  state_nxt = CMD_RD;
                    else                    state_nxt = CMD_WR;
                end
            end
            CMD_WR:    if (cmd_fire) state_nxt = DATA_WR;
            DATA_WR:   if (wr_beat && (wr_cnt == last_idx)) state_nxt = WAIT_IDLE;
            CMD_RD:    if (cmd_fire && (cmd_cnt == last_idx)) state_nxt = WAIT_RD;
            WAIT_RD:   if (rd_beat && (rd_cnt == last_idx)) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (!master_busy_q) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                         <= IDLE;
            len_q                         <= '0;
            wr_cnt                        <= '0;
            cmd_cnt                       <= '0;
            rd_cnt                        <= '0;
            master_busy_q                 <= 1'b0;
            bus.m_axis_cmd_address        <= 7'h00;
            bus.m_axis_cmd_read           <= 1'b0;
            bus.m_axis_cmd_write_multiple <= 1'b0;
            bus.m_axis_cmd_stop           <= 1'b0;
            bus.m_axis_cmd_valid          <= 1'b0;
            bus.done                      <= 1'b0;
            bus.err_nack                  <= 1'b0;
            bus.err_len                   <= 1'b0;
            bus.busy                      <= 1'b0;
        end else begin
            state         <= state_nxt;
            master_busy_q <= bus.master_busy;
            // done is registered off DONE, so busy drops on the same edge done rises.
            bus.done      <= (state == DONE);
            if (state == DONE) bus.busy <= 1'b0;
            if ((state != IDLE) && bus.missed_ack) bus.err_nack <= 1'b1;
            if (wr_beat) wr_cnt <= wr_cnt + LEN_W'(1);
            if (rd_beat) rd_cnt <= rd_cnt + LEN_W'(1);

            if (cmd_fire) begin
                cmd_cnt <= cmd_cnt + LEN_W'(1);
                if ((state == CMD_WR) || (cmd_cnt == last_idx)) begin
                    bus.m_axis_cmd_valid          <= 1'b0;
                    bus.m_axis_cmd_address        <= 7'h00;
                    bus.m_axis_cmd_read           <= 1'b0;
                    bus.m_axis_cmd_write_multiple <= 1'b0;
                    bus.m_axis_cmd_stop           <= 1'b0;
                end else begin
                    // Next read command is the last one when the incremented count hits len-1.
                    bus.m_axis_cmd_stop <= ((cmd_cnt + LEN_W'(1)) == last_idx);
                end
            end

            if (req_fire) begin
                len_q        <= bus.req_len;
                wr_cnt       <= '0;
                cmd_cnt      <= '0;
                rd_cnt       <= '0;
                bus.err_nack <= 1'b0;
                bus.err_len  <= (bus.req_len == '0);
                bus.busy     <= 1'b1;
                if (bus.req_len != '0) begin
                    bus.m_axis_cmd_valid          <= 1'b1;
                    bus.m_axis_cmd_address        <= bus.req_addr;
                    bus.m_axis_cmd_read           <= bus.req_read;
                    bus.m_axis_cmd_write_multiple <= !bus.req_read;
                    bus.m_axis_cmd_stop           <= !bus.req_read || (bus.req_len == LEN_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer: transaction table driven against a small i2c_master
// stand-in, plus hand-written reset sequences.
module tb_i2c_xfer_sequencer;
    localparam int         LEN_W        = 8;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] dbg_state;

    i2c_xfer_if #(.LEN_W(LEN_W)) bus ();

    i2c_xfer_sequencer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic        rd;
        int          len;
        logic [31:0] bytes;      // first byte in bits 31:24
        int          nack_mode;  // 0 none, 1 early pulse, 2 pulse on the WAIT_IDLE->DONE cycle
        int          rd_hold;    // m_axis_rd_tready low up to this cycle
        logic        wr_stall;   // m_axis_data_tready low on odd cycles
        int          exp_cmds;
        logic        exp_err_len;
        logic        exp_err_nack;
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int i);
        return w[31-8*i -: 8];
    endfunction

    function automatic logic [63:0] outs_vec();
        return {25'd0,
                bus.m_axis_cmd_address, bus.m_axis_cmd_start, bus.m_axis_cmd_read,
                bus.m_axis_cmd_write, bus.m_axis_cmd_write_multiple, bus.m_axis_cmd_stop,
                bus.m_axis_cmd_valid, bus.m_axis_data_tdata, bus.m_axis_data_tvalid,
                bus.m_axis_data_tlast, bus.s_axis_wr_tready, bus.m_axis_rd_tdata,
                bus.m_axis_rd_tvalid, bus.m_axis_rd_tlast, bus.s_axis_data_tready,
                bus.done, bus.err_nack, bus.err_len, bus.busy};
    endfunction

    function automatic logic [11:0] cmd_bits();
        return {bus.m_axis_cmd_address, bus.m_axis_cmd_start, bus.m_axis_cmd_read,
                bus.m_axis_cmd_write, bus.m_axis_cmd_write_multiple, bus.m_axis_cmd_stop};
    endfunction

    task automatic drive_idle();
        bus.req_valid          = 1'b0;
        bus.req_addr           = 7'h00;
        bus.req_read           = 1'b0;
        bus.req_len            = '0;
        bus.s_axis_wr_tdata    = 8'h00;
        bus.s_axis_wr_tvalid   = 1'b0;
        bus.m_axis_rd_tready   = 1'b0;
        bus.m_axis_cmd_ready   = 1'b0;
        bus.m_axis_data_tready = 1'b0;
        bus.s_axis_data_tdata  = 8'h00;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tlast  = 1'b0;
        bus.master_busy        = 1'b0;
        bus.missed_ack         = 1'b0;
    endtask

    task automatic run_xfer(input int id, input vec_t v);
        int          cmds = 0, wr_src = 0, wr_beats = 0, rd_pend = 0, rd_sent = 0, rd_beats = 0;
        int          tail = 0, drop_cyc = 0;
        bit          mbusy = 0, prev_mbusy = 0, nack_sent = 0, got_done = 0, prev_fire = 0;
        logic [11:0] exp_cmd;
        logic [7:0]  b;
        @(posedge clk); #1;
        drive_idle();
        bus.req_valid        = 1'b1;
        bus.req_addr         = v.addr;
        bus.req_read         = v.rd;
        bus.req_len          = LEN_W'(v.len);
        bus.s_axis_wr_tvalid = !v.rd && (v.len > 0);
        bus.s_axis_wr_tdata  = byte_at(v.bytes, 0);
        #1;
        check($sformatf("v%0d req_ready", id), bus.req_ready, 1);
        check($sformatf("v%0d wr_tready_idle", id), bus.s_axis_wr_tready, 0);
        for (int i = 0; i < v.len; i++) exp_q.push_back(byte_at(v.bytes, i));

        for (int k = 1; k <= 300 && !got_done; k++) begin
            @(posedge clk); #1;
            bus.req_valid          = 1'b0;
            prev_mbusy             = bus.master_busy;
            bus.master_busy        = mbusy;
            bus.m_axis_cmd_ready   = (k > 2);
            bus.missed_ack         = 1'b0;
            if (v.nack_mode == 1 && cmds > 0 && !nack_sent) begin
                bus.missed_ack = 1'b1;
                nack_sent      = 1;
            end
            if (v.nack_mode == 2 && !nack_sent && dbg_state == ST_WAIT_IDLE && !prev_mbusy) begin
                bus.missed_ack = 1'b1;
                nack_sent      = 1;
            end
            bus.s_axis_wr_tvalid   = !v.rd && (wr_src < v.len);
            bus.s_axis_wr_tdata    = (wr_src < v.len) ? byte_at(v.bytes, wr_src) : 8'h00;
            bus.m_axis_data_tready = !(v.wr_stall && (k % 2 == 1));
            bus.s_axis_data_tvalid = (rd_pend > 0);
            bus.s_axis_data_tdata  = (rd_pend > 0) ? byte_at(v.bytes, rd_sent) : 8'h00;
            bus.s_axis_data_tlast  = (rd_sent == v.len - 1);
            bus.m_axis_rd_tready   = (k > v.rd_hold);
            #1;

            if (k <= 2) check($sformatf("v%0d cmd_valid_c%0d", id, k), bus.m_axis_cmd_valid, v.len != 0);
            if (prev_fire && v.rd && cmds < v.len)
                check($sformatf("v%0d cmd_b2b", id), bus.m_axis_cmd_valid, 1);
            prev_fire = 0;
            if (bus.m_axis_cmd_valid) begin
                exp_cmd = {v.addr, 1'b0, v.rd, 1'b0, !v.rd, v.rd ? (cmds == v.len - 1) : 1'b1};
                check($sformatf("v%0d cmd%0d_fields", id, cmds), cmd_bits(), exp_cmd);
                if (bus.m_axis_cmd_ready) begin
                    cmds++;
                    if (v.rd) rd_pend++;
                    prev_fire = 1;
                    mbusy     = 1;
                end
            end

            if (bus.s_axis_wr_tvalid && bus.s_axis_wr_tready) wr_src++;
            if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) begin
                if (exp_q.size() == 0) check($sformatf("v%0d extra_wr_beat", id), 1, 0);
                else begin
                    b = exp_q.pop_front();
                    check($sformatf("v%0d wr_beat%0d", id, wr_beats),
                          {bus.m_axis_data_tlast, bus.m_axis_data_tdata}, {wr_beats == v.len - 1, b});
                end
                wr_beats++;
            end

            if (v.rd_hold > 0 && k == v.rd_hold && rd_pend > 0)
                check($sformatf("v%0d rd_held", id),
                      {bus.s_axis_data_tready, bus.m_axis_rd_tvalid}, 2'b01);
            if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) begin
                rd_pend--;
                rd_sent++;
            end
            if (bus.m_axis_rd_tvalid && bus.m_axis_rd_tready) begin
                if (exp_q.size() == 0) check($sformatf("v%0d extra_rd_beat", id), 1, 0);
                else begin
                    b = exp_q.pop_front();
                    check($sformatf("v%0d rd_beat%0d", id, rd_beats),
                          {bus.m_axis_rd_tlast, bus.m_axis_rd_tdata}, {rd_beats == v.len - 1, b});
                end
                rd_beats++;
            end

            if (mbusy && (v.rd ? (rd_sent == v.len) : (wr_beats == v.len))) begin
                if (tail == 3) begin
                    mbusy    = 0;
                    drop_cyc = k + 1;
                end else tail++;
            end

            if (bus.done) begin
                got_done = 1;
                check($sformatf("v%0d err_len", id), bus.err_len, v.exp_err_len);
                check($sformatf("v%0d err_nack", id), bus.err_nack, v.exp_err_nack);
                check($sformatf("v%0d busy_at_done", id), bus.busy, 0);
                check($sformatf("v%0d cmd_count", id), cmds, v.exp_cmds);
                check($sformatf("v%0d beat_count", id), wr_beats + rd_beats, v.len);
                if (v.len == 0) check($sformatf("v%0d done_latency", id), k, 2);
                else check($sformatf("v%0d done_after_idle", id), k >= drop_cyc + 2, 1);
            end else if (k > 1 && !got_done) begin
                if (k == 2 || k == 50) check($sformatf("v%0d busy_c%0d", id, k), bus.busy, 1);
            end
        end
        if (!got_done) check($sformatf("v%0d done_timeout", id), 0, 1);
        exp_q.delete();

        @(posedge clk); #1;
        drive_idle();
        #1;
        check($sformatf("v%0d post_done", id), {bus.done, bus.req_ready, dbg_state}, {2'b01, ST_IDLE});
    endtask

    initial begin
        int beats;
        vec_t v;
        vecs[0] = '{addr: 7'h22, rd: 0, len: 4, bytes: 32'h11223344, nack_mode: 0, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 1, exp_err_len: 0, exp_err_nack: 0};
        vecs[1] = '{addr: 7'h2a, rd: 1, len: 3, bytes: 32'hA1A2A300, nack_mode: 0, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 3, exp_err_len: 0, exp_err_nack: 0};
        vecs[2] = '{addr: 7'h30, rd: 0, len: 0, bytes: 32'h0, nack_mode: 0, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 0, exp_err_len: 1, exp_err_nack: 0};
        vecs[3] = '{addr: 7'h10, rd: 0, len: 2, bytes: 32'h5AA50000, nack_mode: 1, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 1, exp_err_len: 0, exp_err_nack: 1};
        vecs[4] = '{addr: 7'h2a, rd: 1, len: 2, bytes: 32'hB1B20000, nack_mode: 0, rd_hold: 22,
                    wr_stall: 0, exp_cmds: 2, exp_err_len: 0, exp_err_nack: 0};
        vecs[5] = '{addr: 7'h22, rd: 0, len: 3, bytes: 32'h01020300, nack_mode: 2, rd_hold: 0,
                    wr_stall: 1, exp_cmds: 1, exp_err_len: 0, exp_err_nack: 1};
        vecs[6] = '{addr: 7'h2a, rd: 1, len: 1, bytes: 32'hC3000000, nack_mode: 0, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 1, exp_err_len: 0, exp_err_nack: 0};
        vecs[7] = '{addr: 7'h2a, rd: 1, len: 0, bytes: 32'h0, nack_mode: 0, rd_hold: 0,
                    wr_stall: 0, exp_cmds: 0, exp_err_len: 1, exp_err_nack: 0};

        // reset state
        drive_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_outputs", outs_vec(), 64'd0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        #1;
        check("req_ready_after_reset", bus.req_ready, 1);

        for (int i = 0; i < 8; i++) run_xfer(i, vecs[i]);

        // reset in the middle of a 4-byte write, after the second beat
        @(posedge clk); #1;
        drive_idle();
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'h22;
        bus.req_len   = LEN_W'(4);
        beats = 0;
        for (int k = 0; k < 50 && beats < 2; k++) begin
            @(posedge clk); #1;
            bus.req_valid          = 1'b0;
            bus.m_axis_cmd_ready   = 1'b1;
            bus.m_axis_data_tready = 1'b1;
            bus.master_busy        = 1'b1;
            bus.s_axis_wr_tvalid   = 1'b1;
            bus.s_axis_wr_tdata    = 8'h70 + 8'(beats);
            #1;
            if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) beats++;
        end
        check("mid_beats_seen", beats, 2);
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b0;
        #1;
        check("mid_req_ready_in_reset", bus.req_ready, 0);
        @(posedge clk); #1;
        check("mid_reset_outputs", outs_vec(), 64'd0);
        check("mid_reset_state", {bus.req_ready, dbg_state}, {1'b0, ST_IDLE});
        rst = 1'b1;
        #1;
        check("mid_req_ready_after", bus.req_ready, 1);

        v = '{addr: 7'h22, rd: 0, len: 1, bytes: 32'hEE000000, nack_mode: 0, rd_hold: 0,
              wr_stall: 0, exp_cmds: 1, exp_err_len: 0, exp_err_nack: 0};
        run_xfer(8, v);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
